stream_burst_host: RTL

//  Host-side end of the in_valid/in_data -> out_valid/out_data burst protocol used by the core.

---
 rtl/stream_burst_host.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/stream_burst_host.sv
`default_nettype none
// ============================================================================
// Module   : stream_burst_host
// Function : Sends one TX-buffer burst to the core, captures the returned
//            burst into an RX buffer and checks its length and data.
// Revision : 1.0 - initial release
// ============================================================================
module stream_burst_host #(
    parameter int DW      = 16,
    parameter int AW      = 2,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   rx_count,
    output logic          err_data,
    output logic          err_len,
    output logic          err_to
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [TW-1:0] C_TMO = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   tx_buf_q [DEPTH];
    logic [DW-1:0]   tx_buf_d [DEPTH];
    logic [DW-1:0]   rx_buf_q [DEPTH];
    logic [DW-1:0]   rx_buf_d [DEPTH];
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     tx_idx_q, tx_idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [AW:0]     rx_count_q, rx_count_d;
    logic            tx_valid_q, tx_valid_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_data_q, err_data_d;
    logic            err_len_q, err_len_d;
    logic            err_to_q, err_to_d;

    always_comb begin
        state_d    = state_q;
        tx_buf_d   = tx_buf_q;
        rx_buf_d   = rx_buf_q;
        len_d      = len_q;
        tx_idx_d   = tx_idx_q;
        tmo_d      = tmo_q;
        rx_count_d = rx_count_q;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        done_d     = 1'b0;
        err_data_d = err_data_q;
        err_len_d  = err_len_q;
        err_to_d   = err_to_q;

        case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    tx_buf_d[ld_addr] = ld_data;
                end
                if (start && (len != '0)) begin
                    len_d      = (len > C_DEPTH) ? C_DEPTH : len;
                    tx_idx_d   = {{AW{1'b0}}, 1'b1};
                    tx_valid_d = 1'b1;
                    // Read the post-write buffer so a same-cycle load of word 0 is sent.
                    tx_data_d  = tx_buf_d[0];
                    rx_count_d = '0;
                    err_data_d = 1'b0;
                    err_len_d  = 1'b0;
                    err_to_d   = 1'b0;
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_idx_q == len_q) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = tx_buf_q[tx_idx_q[AW-1:0]];
                    tx_idx_d   = tx_idx_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (rx_valid) begin
                    rx_buf_d[0] = rx_data;
                    rx_count_d  = {{AW{1'b0}}, 1'b1};
                    if (rx_data != tx_buf_q[0]) begin
                        err_data_d = 1'b1;
                    end
                    state_d = S_RECV;
                end else if ((tmo_q + 1'b1) == C_TMO) begin
                    err_to_d  = 1'b1;
                    err_len_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_RECV: begin
                if (rx_valid) begin
                    if (rx_count_q < C_DEPTH) begin
                        rx_buf_d[rx_count_q[AW-1:0]] = rx_data;
                        rx_count_d = rx_count_q + 1'b1;
                        if ((rx_count_q < len_q) && (rx_data != tx_buf_q[rx_count_q[AW-1:0]])) begin
                            err_data_d = 1'b1;
                        end
                    end else begin
                        err_len_d = 1'b1;
                    end
                end else begin
                    // Length is final here, so flag it together with the done pulse.
                    if (rx_count_q != len_q) begin
                        err_len_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        tx_buf_q <= tx_buf_d;
        rx_buf_q <= rx_buf_d;
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            tx_idx_q   <= '0;
            tmo_q      <= '0;
            rx_count_q <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_data_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            tx_idx_q   <= tx_idx_d;
            tmo_q      <= tmo_d;
            rx_count_q <= rx_count_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_data_q <= err_data_d;
            err_len_q  <= err_len_d;
            err_to_q   <= err_to_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_count = rx_count_q;
    assign err_data = err_data_q;
    assign err_len  = err_len_q;
    assign err_to   = err_to_q;
    assign rd_data  = rx_buf_q[rd_addr];

endmodule
`default_nettype wire
